fabric_boot_sequencer: RTL and testbench

//   Bitstream source sequencer between N bitstream sources and fabric_config.

---
 rtl/fabric_boot_sequencer_if.sv | 40 ++++
 rtl/fabric_boot_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_fabric_boot_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fabric_boot_sequencer_if.sv
// Bitstream sequencer bus: source words, SPI controller handshake, warmboot, config out.
// Latency: none (wires only).
// Backpressure: none; config words are pushed and must be accepted every cycle.
interface fabric_boot_sequencer_if #(
  parameter int          NUM_SOURCES     = 2,
  parameter int          DATA_WIDTH      = 32,
  parameter int          SLOT_WIDTH      = 4,
  parameter int unsigned BITSTREAM_WORDS = 32'h1762,
  parameter int          MODE_WIDTH      = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1,
  parameter int          COUNT_WIDTH     = $clog2(BITSTREAM_WORDS + 1)
);
  logic [MODE_WIDTH-1:0]             mode_i;
  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data_i;
  logic [NUM_SOURCES-1:0]            src_valid_i;
  logic                              ctrl_start_o;
  logic [SLOT_WIDTH-1:0]             ctrl_slot_o;
  logic                              ctrl_busy_i;
  logic                              warmboot_boot_i;
  logic [SLOT_WIDTH-1:0]             warmboot_slot_i;
  logic                              warmboot_reset_o;
  logic [DATA_WIDTH-1:0]             cfg_data_o;
  logic                              cfg_valid_o;
  logic                              busy_o;
  logic                              error_o;
  logic [COUNT_WIDTH-1:0]            word_count_o;

  // Environment side: drives sources, controller status and warmboot requests.
  modport master (
    output mode_i, src_data_i, src_valid_i, ctrl_busy_i, warmboot_boot_i, warmboot_slot_i,
    input  ctrl_start_o, ctrl_slot_o, warmboot_reset_o, cfg_data_o, cfg_valid_o,
           busy_o, error_o, word_count_o
  );

  // Sequencer side.
  modport slave (
    input  mode_i, src_data_i, src_valid_i, ctrl_busy_i, warmboot_boot_i, warmboot_slot_i,
    output ctrl_start_o, ctrl_slot_o, warmboot_reset_o, cfg_data_o, cfg_valid_o,
           busy_o, error_o, word_count_o
  );
endinterface

// File: rtl/fabric_boot_sequencer.sv
// Selects one bitstream source, launches SPI fetches (startup/warmboot/golden retry), forwards words to fabric_config.
// Latency: 1 cycle from a source word to cfg_valid_o/cfg_data_o.
// Backpressure: none; words from the latched source are forwarded as they arrive, excess words dropped.
module fabric_boot_sequencer #(
  parameter int          NUM_SOURCES     = 2,
  parameter int          DATA_WIDTH      = 32,
  parameter int          SLOT_WIDTH      = 4,
  parameter int unsigned BITSTREAM_WORDS = 32'h1762,
  parameter int          TIMEOUT_CYCLES  = 65536
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  fabric_boot_sequencer_if.slave bus
);
  localparam int MODE_WIDTH  = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int COUNT_WIDTH = $clog2(BITSTREAM_WORDS + 1);
  localparam int TMO_WIDTH   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_DONE,
    ST_ERROR
  } state_e;

  state_e                  state_q, state_d;
  logic [SLOT_WIDTH-1:0]   slot_q, slot_d;        // slot of the current/last fetch
  logic [SLOT_WIDTH-1:0]   wb_slot_q, wb_slot_d;  // most recent warmboot slot request
  logic                    pend_q, pend_d;
  logic                    retry_q, retry_d;
  logic [MODE_WIDTH-1:0]   src_q, src_d;
  logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [TMO_WIDTH-1:0]    tmo_q, tmo_d;
  logic                    cfg_vld_q, cfg_vld_d;
  logic [DATA_WIDTH-1:0]   cfg_dat_q, cfg_dat_d;
  logic                    err_q, err_d;

  logic [MODE_WIDTH-1:0]   sel;
  logic [DATA_WIDTH-1:0]   sel_dat;
  logic                    sel_vld;

  // In LOAD the latched source is used, otherwise the live mode selection.
  assign sel = (state_q == ST_LOAD) ? src_q : bus.mode_i;

  // Mux the selected source's word and valid out of the packed source bus.
  always_comb begin
    sel_dat = '0;
    sel_vld = 1'b0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      if (sel == MODE_WIDTH'(k)) begin
        sel_dat = bus.src_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        sel_vld = bus.src_valid_i[k];
      end
    end
  end

  // Next-state and datapath updates for the sequencer FSM.
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    wb_slot_d = wb_slot_q;
    pend_d    = pend_q;
    retry_d   = retry_q;
    src_d     = src_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    cfg_vld_d = 1'b0;
    cfg_dat_d = cfg_dat_q;
    err_d     = err_q;

    // A request that is not consumed right away is remembered; last one wins.
    if (bus.warmboot_boot_i) begin
      pend_d    = 1'b1;
      wb_slot_d = bus.warmboot_slot_i;
    end

    case (state_q)
      ST_STARTUP: begin
        if (bus.mode_i == '0) begin
          state_d = ST_FETCH;
          slot_d  = '0;
          src_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if ((bus.mode_i == '0) && (bus.warmboot_boot_i || pend_q) && !bus.ctrl_busy_i) begin
          state_d = ST_FETCH;
          slot_d  = bus.warmboot_boot_i ? bus.warmboot_slot_i : wb_slot_q;
          src_d   = '0;
          pend_d  = 1'b0;
        end else if ((bus.mode_i != '0) && sel_vld) begin
          // Passive source: the word that wakes us up is already word 1.
          src_d     = bus.mode_i;
          cfg_vld_d = 1'b1;
          cfg_dat_d = sel_dat;
          cnt_d     = COUNT_WIDTH'(1);
          tmo_d     = '0;
          state_d   = (cnt_d == COUNT_WIDTH'(BITSTREAM_WORDS)) ? ST_DONE : ST_LOAD;
        end
      end
      ST_FETCH: begin
        cnt_d   = '0;
        tmo_d   = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (sel_vld) begin
          cfg_vld_d = 1'b1;
          cfg_dat_d = sel_dat;
          cnt_d     = cnt_q + 1'b1;
          tmo_d     = '0;
          if (cnt_d == COUNT_WIDTH'(BITSTREAM_WORDS)) begin
            state_d = ST_DONE;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_q == TMO_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        err_d   = 1'b0;
        retry_d = 1'b0;
        state_d = ST_IDLE;
      end
      ST_ERROR: begin
        // One retry from the golden image, only for a failed non-golden SPI load.
        if ((src_q == '0) && !retry_q && (slot_q != '0)) begin
          retry_d = 1'b1;
          slot_d  = '0;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_STARTUP;
    end else begin
      state_q <= state_d;
    end
  end

  // Slot, request, counter and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_q    <= '0;
      wb_slot_q <= '0;
      pend_q    <= 1'b0;
      retry_q   <= 1'b0;
      src_q     <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      cfg_vld_q <= 1'b0;
      cfg_dat_q <= '0;
      err_q     <= 1'b0;
    end else begin
      slot_q    <= slot_d;
      wb_slot_q <= wb_slot_d;
      pend_q    <= pend_d;
      retry_q   <= retry_d;
      src_q     <= src_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      cfg_vld_q <= cfg_vld_d;
      cfg_dat_q <= cfg_dat_d;
      err_q     <= err_d;
    end
  end

  // Busy window covers the whole fetch/load/done sequence; the fabric warmboot logic is held with it.
  assign bus.busy_o           = (state_q == ST_FETCH) || (state_q == ST_LOAD) || (state_q == ST_DONE);
  assign bus.warmboot_reset_o = bus.busy_o;
  assign bus.ctrl_start_o     = (state_q == ST_FETCH);
  assign bus.ctrl_slot_o      = (state_q == ST_FETCH) ? slot_q : '0;
  assign bus.cfg_data_o       = cfg_dat_q;
  assign bus.cfg_valid_o      = cfg_vld_q;
  assign bus.error_o          = err_q;
  assign bus.word_count_o     = cnt_q;
endmodule

// File: tb/tb_fabric_boot_sequencer.sv
// Directed bench for fabric_boot_sequencer: startup, passive source, warmboot, pending, timeout/retry, async reset.
// Latency: checks cfg words one cycle after presentation.
// Backpressure: none modelled; sources stream back-to-back.
module tb_fabric_boot_sequencer;
  localparam int          NS    = 2;
  localparam int          DW    = 32;
  localparam int          SW    = 4;
  localparam int unsigned WORDS = 32'h1762;
  localparam int          TMO   = 64;

  logic clk;
  logic rst_n;
  int   vec_cnt;
  int   miscmp_cnt;
  int   start_cnt;
  int   start_before;

  fabric_boot_sequencer_if #(
    .NUM_SOURCES(NS), .DATA_WIDTH(DW), .SLOT_WIDTH(SW), .BITSTREAM_WORDS(WORDS)
  ) bus ();

  fabric_boot_sequencer #(
    .NUM_SOURCES(NS), .DATA_WIDTH(DW), .SLOT_WIDTH(SW),
    .BITSTREAM_WORDS(WORDS), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count start pulses (each lasts one cycle) sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.ctrl_start_o === 1'b1) start_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input int src, input int i);
    return 32'hA500_0000 ^ (32'(src) << 28) ^ 32'(i);
  endfunction

  // Stream n words from src, optionally toggling junk on source 0 and
  // raising a one-cycle warmboot request at word index wb_at.
  task automatic load_words(input string tag, input int src, input int n, input int wb_at,
                            input logic [SW-1:0] wb_slot, input bit alt0);
    int          bad;
    logic [31:0] w;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      w = word_of(src, i);
      bus.src_valid_i = '0;
      bus.src_valid_i[src] = 1'b1;
      bus.src_data_i[src*DW +: DW] = w;
      if (alt0) begin
        bus.src_valid_i[0] = i[0];
        bus.src_data_i[DW-1:0] = 32'hDEAD_0000 | 32'(i);
      end
      bus.warmboot_boot_i = (i == wb_at);
      bus.warmboot_slot_i = wb_slot;
      step();
      if (!(bus.cfg_valid_o === 1'b1 && bus.cfg_data_o === w)) bad++;
    end
    bus.src_valid_i     = '0;
    bus.warmboot_boot_i = 1'b0;
    check_vec(tag, 32'(bad), 32'd0);
  endtask

  initial begin
    vec_cnt    = 0;
    miscmp_cnt = 0;
    start_cnt  = 0;
    rst_n               = 1'b0;
    bus.mode_i          = '0;
    bus.src_data_i      = '0;
    bus.src_valid_i     = '0;
    bus.ctrl_busy_i     = 1'b0;
    bus.warmboot_boot_i = 1'b0;
    bus.warmboot_slot_i = '0;

    // Reset state.
    step();
    check_vec("rst_busy",   32'(bus.busy_o), 32'd0);
    check_vec("rst_start",  32'(bus.ctrl_start_o), 32'd0);
    check_vec("rst_cfgv",   32'(bus.cfg_valid_o), 32'd0);
    check_vec("rst_err",    32'(bus.error_o), 32'd0);
    check_vec("rst_wc",     32'(bus.word_count_o), 32'd0);
    check_vec("rst_wbrst",  32'(bus.warmboot_reset_o), 32'd0);

    // Startup fetch from slot 0 and a full load.
    rst_n = 1'b1;
    step();
    check_vec("su_start",   32'(bus.ctrl_start_o), 32'd1);
    check_vec("su_slot",    32'(bus.ctrl_slot_o), 32'd0);
    check_vec("su_busy",    32'(bus.busy_o), 32'd1);
    check_vec("su_wbrst",   32'(bus.warmboot_reset_o), 32'd1);
    step();
    check_vec("su_start_1cyc", 32'(bus.ctrl_start_o), 32'd0);
    load_words("su_words", 0, WORDS, -1, '0, 1'b0);
    check_vec("su_done_busy", 32'(bus.busy_o), 32'd1);
    check_vec("su_wc",      32'(bus.word_count_o), WORDS);
    bus.src_valid_i[0] = 1'b1;
    bus.src_data_i[DW-1:0] = 32'h1234_5678;
    step();
    check_vec("su_busy_fall",  32'(bus.busy_o), 32'd0);
    check_vec("su_excess_v",   32'(bus.cfg_valid_o), 32'd0);
    step();
    check_vec("su_excess_v2",  32'(bus.cfg_valid_o), 32'd0);
    check_vec("su_wc_hold",    32'(bus.word_count_o), WORDS);
    bus.src_valid_i = '0;

    // Passive source 1 with source 0 toggling junk.
    bus.mode_i   = 1'b1;
    start_before = start_cnt;
    load_words("m1_words", 1, WORDS, -1, '0, 1'b1);
    check_vec("m1_wc",      32'(bus.word_count_o), WORDS);
    step();
    check_vec("m1_busy_fall", 32'(bus.busy_o), 32'd0);
    check_vec("m1_no_start",  32'(start_cnt), 32'(start_before));
    bus.mode_i = 1'b0;

    // Warmboot slot 5 from IDLE, slot 7 arrives mid-load and goes pending.
    bus.warmboot_boot_i = 1'b1;
    bus.warmboot_slot_i = 4'd5;
    step();
    check_vec("wb5_start",  32'(bus.ctrl_start_o), 32'd1);
    check_vec("wb5_slot",   32'(bus.ctrl_slot_o), 32'd5);
    bus.warmboot_boot_i = 1'b0;
    step();
    check_vec("wb5_wc_clr", 32'(bus.word_count_o), 32'd0);
    load_words("wb5_words", 0, WORDS, 100, 4'd7, 1'b0);
    check_vec("wb5_wc",     32'(bus.word_count_o), WORDS);
    step();
    check_vec("wb5_idle",   32'(bus.busy_o), 32'd0);
    step();
    check_vec("wb7_start",  32'(bus.ctrl_start_o), 32'd1);
    check_vec("wb7_slot",   32'(bus.ctrl_slot_o), 32'd7);
    step();
    load_words("wb7_words", 0, WORDS, -1, '0, 1'b0);
    step();
    step();
    check_vec("wb7_no_refetch", 32'(bus.ctrl_start_o), 32'd0);
    check_vec("wb7_idle",   32'(bus.busy_o), 32'd0);

    // Slot 3 stalls after 10 words: timeout, then golden retry.
    bus.warmboot_boot_i = 1'b1;
    bus.warmboot_slot_i = 4'd3;
    step();
    check_vec("s3_slot",    32'(bus.ctrl_slot_o), 32'd3);
    bus.warmboot_boot_i = 1'b0;
    step();
    load_words("s3_words", 0, 10, -1, '0, 1'b0);
    repeat (TMO - 1) step();
    check_vec("s3_tmo_early", 32'(bus.error_o), 32'd0);
    check_vec("s3_tmo_busy",  32'(bus.busy_o), 32'd1);
    step();
    check_vec("s3_err",     32'(bus.error_o), 32'd1);
    step();
    check_vec("s3_retry",   32'(bus.ctrl_start_o), 32'd1);
    check_vec("s3_retry_slot", 32'(bus.ctrl_slot_o), 32'd0);
    check_vec("s3_err_sticky", 32'(bus.error_o), 32'd1);
    step();
    load_words("retry_words", 0, WORDS, -1, '0, 1'b0);
    check_vec("retry_wc",   32'(bus.word_count_o), WORDS);
    step();
    check_vec("retry_err_clr", 32'(bus.error_o), 32'd0);

    // Slot 0 times out: no retry, later warmboot still accepted.
    bus.warmboot_boot_i = 1'b1;
    bus.warmboot_slot_i = 4'd0;
    step();
    check_vec("s0_start",   32'(bus.ctrl_start_o), 32'd1);
    bus.warmboot_boot_i = 1'b0;
    step();
    load_words("s0_words", 0, 3, -1, '0, 1'b0);
    repeat (TMO) step();
    check_vec("s0_err",     32'(bus.error_o), 32'd1);
    step();
    check_vec("s0_no_retry", 32'(bus.ctrl_start_o), 32'd0);
    check_vec("s0_idle",    32'(bus.busy_o), 32'd0);
    step();
    check_vec("s0_no_retry2", 32'(bus.ctrl_start_o), 32'd0);
    check_vec("s0_err_sticky", 32'(bus.error_o), 32'd1);
    bus.warmboot_boot_i = 1'b1;
    bus.warmboot_slot_i = 4'd2;
    step();
    check_vec("late_start", 32'(bus.ctrl_start_o), 32'd1);
    check_vec("late_slot",  32'(bus.ctrl_slot_o), 32'd2);
    bus.warmboot_boot_i = 1'b0;
    step();
    load_words("late_words", 0, 4, -1, '0, 1'b0);

    // Asynchronous reset mid-load.
    rst_n = 1'b0;
    #1;
    check_vec("arst_busy",  32'(bus.busy_o), 32'd0);
    check_vec("arst_cfgv",  32'(bus.cfg_valid_o), 32'd0);
    check_vec("arst_wc",    32'(bus.word_count_o), 32'd0);
    check_vec("arst_err",   32'(bus.error_o), 32'd0);
    check_vec("arst_wbrst", 32'(bus.warmboot_reset_o), 32'd0);
    check_vec("arst_start", 32'(bus.ctrl_start_o), 32'd0);
    #1;
    rst_n = 1'b1;

    // Warmboot during STARTUP: startup fetch wins, slot 9 goes pending.
    bus.warmboot_boot_i = 1'b1;
    bus.warmboot_slot_i = 4'd9;
    step();
    check_vec("rel_start",  32'(bus.ctrl_start_o), 32'd1);
    check_vec("rel_slot",   32'(bus.ctrl_slot_o), 32'd0);
    bus.warmboot_boot_i = 1'b0;
    step();
    repeat (TMO) step();
    check_vec("pend_tmo_err", 32'(bus.error_o), 32'd1);
    step();
    check_vec("pend_idle_start", 32'(bus.ctrl_start_o), 32'd0);
    step();
    check_vec("pend_start", 32'(bus.ctrl_start_o), 32'd1);
    check_vec("pend_slot",  32'(bus.ctrl_slot_o), 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end
endmodule
